multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multicycle successor to the single-cycle ARM control unit. An FSM sequences each instruction over 3-5 cycles through one shared memory port and one ALU. It holds the NZCV flags in an internal register and evaluates the condition field against those registered flags. It supports memory wait states via a ready handshake, and adds CMP, EOR and a defined behaviour for cond=1111.

Parameters:
ALU_CTRL_W, 2, alu_ctrl width; 2 = ADD/SUB/AND/ORR; 3 also enables EOR (code 3'b100).
MEM_HANDSHAKE, 1, 1 = stall on mem_ready; 0 = mem_ready ignored and treated as 1.
FLAG_W, 4, flag width, ordered {N,Z,C,V}; fixed at 4, other values are illegal.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cond  in  4  instr[31:28], sampled from IR
op  in  2  instr[27:26]; 00 DP, 01 MEM, 10 B
funct  in  6  instr[25:20]
rd  in  4  instr[15:12]
alu_flags  in  FLAG_W  ALU combinational flags {N,Z,C,V}
mem_ready  in  1  memory access completes this cycle
pc_we  out  1  PC write enable
adr_src  out  1  memory address: 0 = PC, 1 = result
mem_we  out  1  data memory write enable
ir_we  out  1  instruction register write enable
result_src  out  2  00 = ALUOut reg, 01 = data reg, 10 = ALU direct
alu_ctrl  out  ALU_CTRL_W  00 ADD, 01 SUB, 10 AND, 11 ORR, (100 EOR)
alu_src_a  out  1  0 = reg A, 1 = PC
alu_src_b  out  2  00 = reg WD, 01 = extended imm, 10 = constant 4
imm_src  out  2  equals op
reg_we  out  1  register file write enable
reg_src  out  2  {str, branch}, same encoding as the single-cycle unit
flags_q  out  FLAG_W  registered flags, for debug/observation

Behaviour:
- Reset (rst_n low, async): state = FETCH; flags_q = 0. Every write enable (pc_we, ir_we, mem_we, reg_we) is forced to 0 while rst_n is low. On release, FETCH begins at the next edge.
- Mux-select outputs are decoded combinationally from state and instruction fields. Unlisted selects default to 0, and alu_ctrl defaults to ADD.
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10. ir_we and pc_we = mem_ready. Hold in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=1, alu_src_b=10 (computes PC+8). Evaluate cond_ex against flags_q.
  - cond_ex=0 → FETCH, with no write this instruction.
  - op=01 → MEM_ADR; op=10 → BRANCH; op=00 → EXEC_I if funct[5], else EXEC_R; op=11 → FETCH (NOP).
- cond_ex table: 0000 Z, 0001 ~Z, 0010 C, 0011 ~C, 0100 N, 0101 ~N, 0110 V, 0111 ~V, 1000 C&~Z, 1001 ~(C&~Z), 1010 ge, 1011 ~ge, 1100 ~Z&ge, 1101 ~(~Z&ge), 1110 1, 1111 0. Here ge = (N==V).
- MEM_ADR: alu_src_b=01, ADD. funct[0]=1 → MEM_RD; funct[0]=0 → MEM_WR.
- MEM_RD: adr_src=1. Stay until mem_ready, then go to MEM_WB.
- MEM_WB: result_src=01. If rd==15, pc_we=1 and reg_we=0; otherwise reg_we=1. Then FETCH.
- MEM_WR: adr_src=1, mem_we=1 every cycle in the state. Exit to FETCH on mem_ready.
- EXEC_R / EXEC_I: alu_src_b = 00 (EXEC_R) or 01 (EXEC_I). alu_ctrl from funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB), 0001 EOR (only when ALU_CTRL_W=3; otherwise ADD). If funct[0]=1, flags_q is updated at the end of the cycle:
  - NZCV for ADD/SUB/CMP;
  - NZ only for AND/ORR/EOR (C and V keep their values).
  - Next state: CMP → FETCH; otherwise ALU_WB.
- ALU_WB: result_src=00. If rd==15, pc_we=1 and reg_we=0; otherwise reg_we=1. Then FETCH.
- BRANCH: alu_src_a=0, alu_src_b=01, ADD, result_src=10, pc_we=1. Then FETCH.
- Latencies with mem_ready tied to 1: B = 3 cycles, DP = 4, CMP = 3, STR = 4, LDR = 5. Each memory wait cycle adds 1.
- Reset asserted mid-instruction: the FSM aborts immediately and no partial writes occur after the reset edge.
- flags_q is only written in EXEC states, and only when cond_ex=1.

Test Plan:
- Reset, then ADDS R1 (cond=1110, op=00, funct=101001, rd=1); ALU flags=0100 → DP takes 4 cycles; reg_we pulses once in ALU_WB; flags_q=0100.
- With Z=1 in flags_q, BNE (cond=0001, op=10) → DECODE returns to FETCH; pc_we asserts only in FETCH; BRANCH is never entered.
- LDR with mem_ready low for 2 cycles in MEM_RD → 7 cycles total; reg_we pulses once; rd=15 gives pc_we instead of reg_we.
- CMP (funct=110101) with alu_flags=0011 → flags_q=0011; reg_we is never asserted; back to FETCH after 3 cycles.
- ANDS with flags_q=0011 and alu_flags=1000 → flags_q=1011.
- cond=1111 on an STR → mem_we stays 0 throughout. Separately, assert rst_n low during MEM_WR → mem_we drops asynchronously and state = FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multicycle ARM-style control FSM. Sequences each instruction through one
//   shared memory port and one ALU. Keeps NZCV in flags_q and evaluates the
//   condition field against those registered flags.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH    | read instruction at PC, PC <= PC+4 (waits on mem_ready)
//   DECODE   | evaluate cond_ex, read registers, ALU computes PC+8
//   MEM_ADR  | compute load/store address (base + imm)
//   MEM_RD   | load data read (waits on mem_ready)
//   MEM_WB   | write loaded data to rd (or PC when rd==15)
//   MEM_WR   | store data write (waits on mem_ready)
//   EXEC_R   | data-processing, register operand; optional flag update
//   EXEC_I   | data-processing, immediate operand; optional flag update
//   ALU_WB   | write ALU result to rd (or PC when rd==15)
//   BRANCH   | PC <= PC+8 + offset
//
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   cond/op/funct/rd instruction fields from IR
//   alu_flags        combinational ALU flags {N,Z,C,V}
//   mem_ready        memory access completes this cycle
//   pc_we/ir_we/mem_we/reg_we   write enables (forced low in reset)
//   adr_src, result_src, alu_ctrl, alu_src_a, alu_src_b, imm_src, reg_src
//                    datapath mux selects
//   flags_q          registered flags {N,Z,C,V}
//   FLAG_W must be 4.

module multicycle_control_unit #(
  parameter int ALU_CTRL_W    = 2,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int FLAG_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [FLAG_W-1:0]     alu_flags,
  input  logic                  mem_ready,
  output logic                  pc_we,
  output logic                  adr_src,
  output logic                  mem_we,
  output logic                  ir_we,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic                  reg_we,
  output logic [1:0]            reg_src,
  output logic [FLAG_W-1:0]     flags_q
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEM_ADR = 4'd2;
  localparam logic [3:0] S_MEM_RD  = 4'd3;
  localparam logic [3:0] S_MEM_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR  = 4'd5;
  localparam logic [3:0] S_EXEC_R  = 4'd6;
  localparam logic [3:0] S_EXEC_I  = 4'd7;
  localparam logic [3:0] S_ALU_WB  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_ORR = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_EOR = ALU_CTRL_W'(4);

  logic [3:0] state, state_n;
  logic       ready;
  logic       cond_ex;
  logic       flag_n, flag_z, flag_c, flag_v, ge;
  logic [ALU_CTRL_W-1:0] dp_alu;
  logic       dp_logic;
  logic       is_cmp;
  logic       in_exec;
  logic       pc_we_raw, ir_we_raw, mem_we_raw, reg_we_raw;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];
  assign ge     = (flag_n == flag_v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~(flag_c & ~flag_z);
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~flag_z & ge;
      4'b1101: cond_ex = ~(~flag_z & ge);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Data-processing op decode; logical ops only touch N and Z.
  always_comb begin
    dp_alu   = ALU_ADD;
    dp_logic = 1'b0;
    is_cmp   = (funct[4:1] == 4'b1010);
    case (funct[4:1])
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: begin dp_alu = ALU_AND; dp_logic = 1'b1; end
      4'b1100: begin dp_alu = ALU_ORR; dp_logic = 1'b1; end
      4'b1010: dp_alu = ALU_SUB;
      4'b0001: begin
        if (ALU_CTRL_W >= 3) begin
          dp_alu   = ALU_EOR;
          dp_logic = 1'b1;
        end
      end
      default: dp_alu = ALU_ADD;
    endcase
  end

  assign in_exec = (state == S_EXEC_R) || (state == S_EXEC_I);

  always_comb begin
    state_n    = state;
    pc_we_raw  = 1'b0;
    ir_we_raw  = 1'b0;
    mem_we_raw = 1'b0;
    reg_we_raw = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    case (state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_we_raw  = ready;
        pc_we_raw  = ready;
        if (ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (!cond_ex) begin
          state_n = S_FETCH;
        end else begin
          case (op)
            2'b01:   state_n = S_MEM_ADR;
            2'b10:   state_n = S_BRANCH;
            2'b00:   state_n = funct[5] ? S_EXEC_I : S_EXEC_R;
            default: state_n = S_FETCH;
          endcase
        end
      end
      S_MEM_ADR: begin
        alu_src_b = 2'b01;
        state_n   = funct[0] ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        adr_src = 1'b1;
        if (ready) state_n = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        if (rd == 4'd15) pc_we_raw  = 1'b1;
        else             reg_we_raw = 1'b1;
        state_n = S_FETCH;
      end
      S_MEM_WR: begin
        adr_src    = 1'b1;
        mem_we_raw = 1'b1;
        if (ready) state_n = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_b = (state == S_EXEC_I) ? 2'b01 : 2'b00;
        alu_ctrl  = dp_alu;
        state_n   = is_cmp ? S_FETCH : S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src = 2'b00;
        if (rd == 4'd15) pc_we_raw  = 1'b1;
        else             reg_we_raw = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_we_raw  = 1'b1;
        state_n    = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // Gate enables with rst_n so nothing writes while reset is held, even
  // though FETCH would otherwise assert ir_we/pc_we.
  assign pc_we  = pc_we_raw  & rst_n;
  assign ir_we  = ir_we_raw  & rst_n;
  assign mem_we = mem_we_raw & rst_n;
  assign reg_we = reg_we_raw & rst_n;

  assign imm_src = op;
  assign reg_src = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (in_exec && funct[0] && cond_ex) begin
      if (dp_logic) flags_q <= {alu_flags[3:2], flags_q[1:0]};
      else          flags_q <= alu_flags;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       pc_we, adr_src, mem_we, ir_we, alu_src_a, reg_we;
  logic [1:0] result_src, alu_ctrl, alu_src_b, imm_src, reg_src;
  logic [3:0] flags_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .pc_we(pc_we),
    .adr_src(adr_src), .mem_we(mem_we), .ir_we(ir_we),
    .result_src(result_src), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_we(reg_we),
    .reg_src(reg_src), .flags_q(flags_q)
  );

  typedef struct {
    logic [3:0] c;
    logic [1:0] o;
    logic [5:0] f;
    logic [3:0] r;
    logic [3:0] af;
    int         waits;
    int         e_cyc;
    int         e_reg;
    int         e_pc;
    int         e_mem;
    int         e_alu;
    logic [3:0] e_flags;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: instruction-level outcome from the condition table and the
  // per-class latencies, without any notion of FSM states.
  task automatic model(input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r,
                       input logic [3:0] af, input int waits,
                       input logic [3:0] fl,
                       output int cyc, output int nreg, output int npc,
                       output int nmem, output int alu,
                       output logic [3:0] fl_n);
    bit n, z, cf, v, ge, ex, is_logic;
    n = fl[3]; z = fl[2]; cf = fl[1]; v = fl[0];
    ge = (n == v);
    case (c)
      4'd0: ex = z;         4'd1: ex = !z;
      4'd2: ex = cf;        4'd3: ex = !cf;
      4'd4: ex = n;         4'd5: ex = !n;
      4'd6: ex = v;         4'd7: ex = !v;
      4'd8: ex = cf && !z;  4'd9: ex = !(cf && !z);
      4'd10: ex = ge;       4'd11: ex = !ge;
      4'd12: ex = !z && ge; 4'd13: ex = !(!z && ge);
      4'd14: ex = 1;        default: ex = 0;
    endcase
    cyc = 2; nreg = 0; npc = 0; nmem = 0; alu = 0; fl_n = fl;
    if (!ex || o == 2'b11) return;
    if (o == 2'b10) begin
      cyc = 3; npc = 1;
    end else if (o == 2'b01) begin
      if (f[0]) begin
        cyc = 5 + waits;
        if (r == 15) npc = 1; else nreg = 1;
      end else begin
        cyc = 4 + waits;
        nmem = 1 + waits;
      end
    end else begin
      is_logic = 0;
      case (f[4:1])
        4'b0100: alu = 0;
        4'b0010: alu = 1;
        4'b0000: begin alu = 2; is_logic = 1; end
        4'b1100: begin alu = 3; is_logic = 1; end
        4'b1010: alu = 1;
        default: alu = 0;
      endcase
      if (f[4:1] == 4'b1010) cyc = 3;
      else begin
        cyc = 4;
        if (r == 15) npc = 1; else nreg = 1;
      end
      if (f[0]) fl_n = is_logic ? {af[3:2], fl[1:0]} : af;
    end
  endtask

  // Entered mid-cycle while the DUT is in FETCH; returns mid-cycle in the
  // next FETCH. Inserts `waits` mem_ready-low cycles on data accesses.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] af, input int waits,
                           output int cyc, output int nreg, output int npc,
                           output int nmem, output int alu);
    int  wl;
    bit  done;
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
    wl = waits; done = 0;
    cyc = 0; nreg = 0; npc = 0; nmem = 0; alu = 0;
    for (int k = 0; k < 30; k++) begin
      mem_ready = 1'b1;
      if (adr_src && wl > 0) begin mem_ready = 1'b0; wl--; end
      if (k > 0) @(negedge clk); else #1;
      if (k > 0 && ir_we) begin done = 1; break; end
      if (k == 0) chk("fetch_start_ir_we", int'(ir_we), 1);
      if (reg_we) nreg++;
      if (pc_we && k > 0) npc++;
      if (mem_we) nmem++;
      if (k == 2) alu = int'(alu_ctrl);
      cyc++;
      @(posedge clk); #1;
    end
    if (!done) chk("instr_timeout", 0, 1);
  endtask

  task automatic apply(input string tag, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r,
                       input logic [3:0] af, input int waits,
                       input int e_cyc, input int e_reg, input int e_pc,
                       input int e_mem, input int e_alu, input logic [3:0] e_fl);
    int cyc, nreg, npc, nmem, alu;
    run_instr(c, o, f, r, af, waits, cyc, nreg, npc, nmem, alu);
    chk({tag, "_cycles"}, cyc, e_cyc);
    chk({tag, "_reg_we"}, nreg, e_reg);
    chk({tag, "_pc_we"}, npc, e_pc);
    chk({tag, "_mem_we"}, nmem, e_mem);
    chk({tag, "_alu_ctrl"}, alu, e_alu);
    chk({tag, "_flags_q"}, int'(flags_q), int'(e_fl));
  endtask

  initial begin
    logic [3:0] fl_model;
    int mc, mr, mp, mm, ma;
    logic [3:0] mf;
    logic [3:0] rc, rr, raf;
    logic [1:0] ro;
    logic [5:0] rf;
    int rw;

    //            cond     op     funct      rd    alu_fl  w  cyc reg pc mem alu flags
    vecs[0]  = '{4'hE, 2'b00, 6'b101001, 4'd1,  4'b0100, 0, 4, 1, 0, 0, 0, 4'b0100}; // ADDS
    vecs[1]  = '{4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, 0, 2, 0, 0, 0, 0, 4'b0100}; // BNE, Z=1
    vecs[2]  = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 0, 3, 0, 1, 0, 0, 4'b0100}; // BEQ
    vecs[3]  = '{4'hE, 2'b01, 6'b011001, 4'd2,  4'b0000, 2, 7, 1, 0, 0, 0, 4'b0100}; // LDR, 2 waits
    vecs[4]  = '{4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, 0, 5, 0, 1, 0, 0, 4'b0100}; // LDR pc
    vecs[5]  = '{4'hE, 2'b00, 6'b110101, 4'd0,  4'b0011, 0, 3, 0, 0, 0, 1, 4'b0011}; // CMP
    vecs[6]  = '{4'hE, 2'b00, 6'b100001, 4'd3,  4'b1000, 0, 4, 1, 0, 0, 2, 4'b1011}; // ANDS
    vecs[7]  = '{4'hF, 2'b01, 6'b011000, 4'd4,  4'b0000, 0, 2, 0, 0, 0, 0, 4'b1011}; // STR nv
    vecs[8]  = '{4'hE, 2'b01, 6'b011000, 4'd4,  4'b0000, 1, 5, 0, 0, 2, 0, 4'b1011}; // STR, 1 wait
    vecs[9]  = '{4'hE, 2'b00, 6'b011000, 4'd15, 4'b1111, 0, 4, 0, 1, 0, 3, 4'b1011}; // ORR pc
    vecs[10] = '{4'hC, 2'b00, 6'b000101, 4'd5,  4'b0110, 0, 4, 1, 0, 0, 1, 4'b0110}; // SUBSGT

    rst_n = 1'b0; mem_ready = 1'b1; cond = 4'hE; op = 2'b00;
    funct = 6'b0; rd = 4'd0; alu_flags = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags_q", int'(flags_q), 0);
    chk("reset_ir_we", int'(ir_we), 0);
    chk("reset_pc_we", int'(pc_we), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      apply($sformatf("vec%0d", i), vecs[i].c, vecs[i].o, vecs[i].f, vecs[i].r,
            vecs[i].af, vecs[i].waits, vecs[i].e_cyc, vecs[i].e_reg,
            vecs[i].e_pc, vecs[i].e_mem, vecs[i].e_alu, vecs[i].e_flags);

    fl_model = 4'b0110;
    for (int i = 0; i < 150; i++) begin
      rc  = 4'($urandom_range(0, 15));
      ro  = 2'($urandom_range(0, 3));
      rf  = 6'($urandom_range(0, 63));
      rr  = 4'($urandom_range(0, 15));
      raf = 4'($urandom_range(0, 15));
      rw  = $urandom_range(0, 2);
      model(rc, ro, rf, rr, raf, rw, fl_model, mc, mr, mp, mm, ma, mf);
      apply($sformatf("rnd%0d", i), rc, ro, rf, rr, raf, rw, mc, mr, mp, mm, ma, mf);
      fl_model = mf;
    end

    // Reset in the middle of a store that is stalled in its write cycle.
    cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'd1; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #2;
    chk("str_mem_we_before_reset", int'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_str_mem_we", int'(mem_we), 0);
    chk("reset_mid_str_adr_src", int'(adr_src), 0);
    chk("reset_mid_str_alu_src_b", int'(alu_src_b), 2);
    chk("reset_mid_str_flags", int'(flags_q), 0);
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after_reset_ir_we", int'(ir_we), 1);
    chk("after_reset_result_src", int'(result_src), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
